// File: rtl/edge_detect_multi_pkg.sv
// Shared constants for the multi-channel edge detector: mode encodings and
// default parameter values.
package edge_detect_multi_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int DEF_N           = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

  function automatic logic edge_hit(input logic [1:0] mode, input logic level,
                                    input logic prev);
    logic rise_en;
    logic fall_en;
    rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
    fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);
    return (rise_en && level && !prev) || (fall_en && !level && prev);
  endfunction

endpackage

// File: rtl/edge_detect_multi_chan.sv
// One channel: synchroniser, edge compare, registered pulse, sticky flag and,
// with EDGE_DETECT_MULTI_EDGE_COUNT_EN, a saturating event counter.
module edge_chan
  import edge_detect_multi_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw,
  input  logic [1:0] mode,
  input  logic       armed,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       sticky,
  output logic       sticky_next
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
  , output logic [CNT_W-1:0] count
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;
  logic                   sticky_q;
  logic                   ev;

  assign level       = sync_q[SYNC_STAGES-1];
  assign ev          = armed && edge_hit(mode, level, prev_q);
  // Set beats clear when both land on the same edge.
  assign sticky_next = ev | (sticky_q & ~clr);
  assign pulse       = pulse_q;
  assign sticky      = sticky_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q   <= level;
      pulse_q  <= ev;
      sticky_q <= sticky_next;
    end
  end

`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q;

  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= ev ? CNT_W'(1) : '0;
    end else if (ev && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/edge_detect_multi.sv
// N-channel synchronised edge detector with sticky flags and AnyEvent summary.
// Define EDGE_DETECT_MULTI_EDGE_COUNT_EN to add per-channel event counters.
module edge_detect_multi
  import edge_detect_multi_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic [N-1:0]   In,
  input  logic [2*N-1:0] Mode,
  input  logic [N-1:0]   Clr,
  output logic [N-1:0]   Level,
  output logic [N-1:0]   Pulse,
  output logic [N-1:0]   Sticky,
  output logic           AnyEvent
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
  , output logic [N*CNT_W-1:0] Count
`endif
);

  if (N < 1 || SYNC_STAGES < 1 || CNT_W < 1) begin : g_bad_params
    $error("edge_detect_multi: N, SYNC_STAGES and CNT_W must all be >= 1");
  end

  // Arm window covers the sync chain plus the Prev stage, so an input already
  // high at reset never looks like a rising edge.
  localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

  logic [ARM_W-1:0] arm_q;
  logic             armed;
  logic [N-1:0]     sticky_next;
  logic             any_q;

  assign armed    = (arm_q == '0);
  assign AnyEvent = any_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      arm_q <= ARM_INIT;
      any_q <= 1'b0;
    end else begin
      if (!armed) arm_q <= arm_q - ARM_W'(1);
      any_q <= |sticky_next;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
      , .CNT_W(CNT_W)
`endif
    ) u_chan (
      .clk        (Clk),
      .reset_n    (Reset_n),
      .raw        (In[gi]),
      .mode       (Mode[2*gi+1 -: 2]),
      .armed      (armed),
      .clr        (Clr[gi]),
      .level      (Level[gi]),
      .pulse      (Pulse[gi]),
      .sticky     (Sticky[gi]),
      .sticky_next(sticky_next[gi])
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
      , .count    (Count[gi*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: pulse scoreboard plus per-scenario
// checks of Level, Sticky, AnyEvent and (EDGE_DETECT_MULTI_EDGE_COUNT_EN) Count.
module tb_edge_detect_multi;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int CW = 4;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic [N-1:0]   In;
  logic [2*N-1:0] Mode;
  logic [N-1:0]   Clr;
  logic [N-1:0]   Level;
  logic [N-1:0]   Pulse;
  logic [N-1:0]   Sticky;
  logic           AnyEvent;
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
  logic [N*CW-1:0] Count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[N][$];

  always #5 Clk = ~Clk;

  edge_detect_multi #(.N(N), .SYNC_STAGES(S), .CNT_W(CW)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .In      (In),
    .Mode    (Mode),
    .Clr     (Clr),
    .Level   (Level),
    .Pulse   (Pulse),
    .Sticky  (Sticky),
    .AnyEvent(AnyEvent)
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
    , .Count (Count)
`endif
  );

  // Scoreboard monitor: every expected pulse cycle is popped and must see
  // Pulse high; any pulse with no matching entry is reported.
  always @(posedge Clk) begin
    #1;
    cyc++;
    for (int ch = 0; ch < N; ch++) begin
      if (exp_q[ch].size() > 0 && exp_q[ch][0] == cyc) begin
        void'(exp_q[ch].pop_front());
        checks++;
        if (Pulse[ch] !== 1'b1) begin
          errors++;
          $display("FAIL pulse_missing ch%0d cyc %0d got %b exp 1", ch, cyc, Pulse[ch]);
        end
      end else if (Pulse[ch] !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pulse_unexpected ch%0d cyc %0d got %b exp 0", ch, cyc, Pulse[ch]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    Mode[2*ch +: 2] = m;
  endtask

  // Drives In[ch]; when the current mode makes this transition an event,
  // queue the edge where the pulse must appear.
  task automatic drive_in(input int ch, input logic v);
    logic [1:0] m;
    m = Mode[2*ch +: 2];
    if ((m[0] && v && !In[ch]) || (m[1] && !v && In[ch]))
      exp_q[ch].push_back(cyc + 1 + S);
    In[ch] = v;
  endtask

  task automatic clear_all();
    Clr = '1;
    step(1);
    Clr = '0;
  endtask

  task automatic check_drained(input string tag);
    for (int ch = 0; ch < N; ch++) begin
      checks++;
      if (exp_q[ch].size() != 0) begin
        errors++;
        $display("FAIL %s_drain ch%0d got %0d pending exp 0", tag, ch, exp_q[ch].size());
        exp_q[ch].delete();
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    In      = '1;
    Mode    = {N{2'b01}};
    Clr     = '0;
    step(3);
    checks++;
    if ({Level, Pulse, Sticky, AnyEvent} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got L=%h P=%h S=%h A=%b exp 0", Level, Pulse, Sticky, AnyEvent);
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (Sticky !== '0 || AnyEvent !== 1'b0) begin
        errors++;
        $display("FAIL reset_arm_sticky cyc %0d got S=%h A=%b exp 0", cyc, Sticky, AnyEvent);
      end
    end
    checks++;
    if (Level !== 8'hFF) begin
      errors++;
      $display("FAIL reset_level got %h exp ff", Level);
    end
  endtask

  task automatic test_rise();
    int e;
    Mode = '0;
    for (int ch = 0; ch < N; ch++) drive_in(ch, 1'b0);
    step(4);
    clear_all();
    checks++;
    if (Sticky !== '0 || AnyEvent !== 1'b0) begin
      errors++;
      $display("FAIL rise_cleared got S=%h A=%b exp 0", Sticky, AnyEvent);
    end
    set_mode(0, 2'b01);
    e = cyc;
    drive_in(0, 1'b1);
    step(1);
    checks++;
    if (Level[0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_level_early got %b exp 0", Level[0]);
    end
    step(1);
    checks++;
    if (Level[0] !== 1'b1 || Sticky[0] !== 1'b0 || AnyEvent !== 1'b0) begin
      errors++;
      $display("FAIL rise_before_pulse got L=%b S=%b A=%b exp 1 0 0", Level[0], Sticky[0], AnyEvent);
    end
    step(1);
    checks++;
    if (cyc != e + 3 || Sticky[0] !== 1'b1 || AnyEvent !== 1'b1) begin
      errors++;
      $display("FAIL rise_sticky got S=%b A=%b exp 1 1", Sticky[0], AnyEvent);
    end
    step(3);
    check_drained("rise");
  endtask

  task automatic test_back_to_back();
    set_mode(1, 2'b11);
    set_mode(2, 2'b10);
    step(2);
    for (int i = 0; i < 4; i++) begin
      drive_in(1, ~In[1]);
      drive_in(2, ~In[2]);
      step(1);
    end
    step(4);
    checks++;
    if (Sticky[2:1] !== 2'b11) begin
      errors++;
      $display("FAIL b2b_sticky got %b exp 11", Sticky[2:1]);
    end
    check_drained("b2b");
  endtask

  task automatic test_sticky_clear();
    set_mode(3, 2'b01);
    clear_all();
    checks++;
    if (Sticky !== '0 || AnyEvent !== 1'b0) begin
      errors++;
      $display("FAIL clr_initial got S=%h A=%b exp 0", Sticky, AnyEvent);
    end
    drive_in(3, 1'b1);
    step(3);
    checks++;
    if (Sticky[3] !== 1'b1 || AnyEvent !== 1'b1) begin
      errors++;
      $display("FAIL clr_set got S=%b A=%b exp 1 1", Sticky[3], AnyEvent);
    end
    drive_in(3, 1'b0);
    step(3);
    drive_in(3, 1'b1);
    step(2);
    Clr = '1;
    step(1);
    checks++;
    if (Sticky[3] !== 1'b1 || AnyEvent !== 1'b1) begin
      errors++;
      $display("FAIL clr_set_wins got S=%b A=%b exp 1 1", Sticky[3], AnyEvent);
    end
    step(1);
    Clr = '0;
    checks++;
    if (Sticky !== '0 || AnyEvent !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone got S=%h A=%b exp 0", Sticky, AnyEvent);
    end
    step(1);
    checks++;
    if (Sticky !== '0 || AnyEvent !== 1'b0) begin
      errors++;
      $display("FAIL clr_after got S=%h A=%b exp 0", Sticky, AnyEvent);
    end
    check_drained("clr");
  endtask

  task automatic test_mode_off();
    clear_all();
    set_mode(0, 2'b01);
    drive_in(0, 1'b0);
    step(3);
    drive_in(0, 1'b1);
    step(4);
    set_mode(0, 2'b00);
    drive_in(0, 1'b0);
    step(2);
    drive_in(0, 1'b1);
    step(4);
    checks++;
    if (Sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL modeoff_sticky got %b exp 1", Sticky[0]);
    end
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
    checks++;
    if (Count[0 +: CW] !== 4'd1) begin
      errors++;
      $display("FAIL modeoff_count got %0d exp 1", Count[0 +: CW]);
    end
`endif
    check_drained("modeoff");
  endtask

`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
  task automatic test_count();
    set_mode(4, 2'b01);
    drive_in(4, 1'b0);
    step(3);
    clear_all();
    checks++;
    if (Count[4*CW +: CW] !== 4'd0) begin
      errors++;
      $display("FAIL count_clear got %0d exp 0", Count[4*CW +: CW]);
    end
    for (int i = 0; i < 10; i++) begin
      drive_in(4, 1'b1); step(1);
      drive_in(4, 1'b0); step(1);
    end
    step(3);
    checks++;
    if (Count[4*CW +: CW] !== 4'd10) begin
      errors++;
      $display("FAIL count_mid got %0d exp 10", Count[4*CW +: CW]);
    end
    for (int i = 0; i < 10; i++) begin
      drive_in(4, 1'b1); step(1);
      drive_in(4, 1'b0); step(1);
    end
    step(4);
    checks++;
    if (Count[4*CW +: CW] !== 4'd15) begin
      errors++;
      $display("FAIL count_saturate got %0d exp 15", Count[4*CW +: CW]);
    end
    drive_in(4, 1'b1);
    step(2);
    Clr[4] = 1'b1;
    step(1);
    Clr = '0;
    checks++;
    if (Count[4*CW +: CW] !== 4'd1 || Sticky[4] !== 1'b1) begin
      errors++;
      $display("FAIL count_clr_edge got C=%0d S=%b exp 1 1", Count[4*CW +: CW], Sticky[4]);
    end
    step(3);
    check_drained("count");
  endtask
`endif

  task automatic test_reset_mid();
    set_mode(5, 2'b01);
    set_mode(6, 2'b01);
    set_mode(7, 2'b01);
    drive_in(5, 1'b0);
    drive_in(6, 1'b0);
    drive_in(7, 1'b0);
    step(3);
    clear_all();
    for (int i = 0; i < 6; i++) begin
      drive_in(5, 1'b1); step(1);
      drive_in(5, 1'b0); step(1);
    end
    drive_in(5, 1'b1);
    step(1);
    drive_in(6, 1'b1);
    step(2);
    checks++;
    if (Pulse[5] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pulse_before got %b exp 1", Pulse[5]);
    end
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
    checks++;
    if (Count[5*CW +: CW] !== 4'd7) begin
      errors++;
      $display("FAIL rmid_count_before got %0d exp 7", Count[5*CW +: CW]);
    end
`endif
    Reset_n = 1'b0;
    exp_q[6].delete();
    step(1);
    checks++;
    if ({Level, Pulse, Sticky, AnyEvent} !== '0) begin
      errors++;
      $display("FAIL rmid_outputs got L=%h P=%h S=%h A=%b exp 0", Level, Pulse, Sticky, AnyEvent);
    end
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
    checks++;
    if (Count !== '0) begin
      errors++;
      $display("FAIL rmid_count got %h exp 0", Count);
    end
`endif
    step(1);
    Reset_n = 1'b1;
    In[7]   = 1'b1;
    for (int i = 0; i < S + 4; i++) begin
      step(1);
      checks++;
      if (Pulse !== '0 || Sticky !== '0) begin
        errors++;
        $display("FAIL rmid_arm cyc %0d got P=%h S=%h exp 0", cyc, Pulse, Sticky);
      end
    end
    drive_in(7, 1'b0);
    step(2);
    drive_in(7, 1'b1);
    step(4);
    checks++;
    if (Sticky !== 8'h80 || AnyEvent !== 1'b1) begin
      errors++;
      $display("FAIL rmid_rearmed got S=%h A=%b exp 80 1", Sticky, AnyEvent);
    end
    check_drained("rmid");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_back_to_back();
    test_sticky_clear();
    test_mode_off();
`ifdef EDGE_DETECT_MULTI_EDGE_COUNT_EN
    test_count();
`endif
    test_reset_mid();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised multi-channel successor to the single-bit rising-edge detector.
- Each of N asynchronous inputs passes through a synchroniser, then a per-channel mode-selectable edge detector (rising, falling, both, off).
- Outputs per channel: a one-cycle registered pulse and a sticky flag with write-one-to-clear.
- Sits between raw board inputs (bumpers, encoders, buttons) and the register/interrupt logic.

Parameters:
N, 8, number of channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
CNT_W, 8, per-channel event counter width (used only with EDGE_COUNT_EN)

Ports:
Clk  input  1  single system clock; all logic on posedge
Reset_n  input  1  synchronous, active-low reset
In  input  N  raw asynchronous inputs
Mode  input  2*N  per channel i, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
Clr  input  N  write-one-to-clear for Sticky (and Count); level-sampled each cycle
Level  output  N  synchronised input level
Pulse  output  N  one-cycle registered edge pulse
Sticky  output  N  latched event flags
AnyEvent  output  1  registered OR of Sticky
Count  output  N*CNT_W  per-channel event counts (EDGE_COUNT_EN only)

Behaviour:
- Reset is sampled on posedge Clk while Reset_n=0. It clears:
  - sync chain, Prev, Pulse, Sticky, AnyEvent, Count to 0;
  - arm counter to SYNC_STAGES+1.
- Synchroniser: In[i] is captured at edge k and appears on Level[i] after edge k+SYNC_STAGES-1.
- Prev[i] is loaded with Level[i] every edge.
- Detection per channel, using Mode:
  - rise = Level & ~Prev
  - fall = ~Level & Prev
  - ev = (Mode[0] & rise) | (Mode[1] & fall)
- Arm counter:
  - Decrements once per cycle after reset until 0.
  - While it is non-zero, ev is forced 0.
  - Purpose: no spurious pulses from an input that is already high at reset.
- Pulse[i] <= ev. Latency: an In change before edge k gives Pulse high from edge k+SYNC_STAGES to k+SYNC_STAGES+1. With defaults, Pulse rises 2 edges after capture.
- Pulse width and spacing:
  - Pulse is exactly one cycle per edge event.
  - Back-to-back toggles in consecutive cycles give consecutive pulses; nothing is merged.
  - Mode 11 pulses on both edges.
- Sticky[i] <= ev | (Sticky[i] & ~Clr[i]).
  - If set and clear coincide in the same cycle, set wins.
- AnyEvent <= |Sticky_next. It is registered in the same edge as Sticky.
- Mode changes:
  - Take effect for the next comparison.
  - Mode 00 stops new events but does not clear Sticky or Count.
- Reset asserted mid-operation clears everything on that edge. A pulse in flight is dropped.

Optional Feature:
- Macro: EDGE_DETECT_MULTI_EDGE_COUNT_EN.
- When defined:
  - Count port and counters exist.
  - Count[i] increments by 1 on each ev[i] and saturates at 2^CNT_W-1 (no wrap).
  - Clr[i] zeroes Count[i].
  - If Clr[i] and ev[i] occur in the same cycle, Count[i] = 1.
- When undefined:
  - Count port is absent and no counter flops are built.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - mode constants: MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - default parameter constants.
- One natural sub-module: edge_chan, covering a single-channel synchroniser, Prev, edge logic, Pulse, Sticky and the optional counter.
- The top instantiates N copies and holds the shared arm counter and AnyEvent.

Test Plan:
- Reset with In=8'hFF held, all Mode=01 → no Pulse and Sticky=0 for 20 cycles after Reset_n rises.
- Ch0 Mode=01, In[0] 0→1 before edge 10 → Pulse[0]=1 only in cycle after edge 12, Sticky[0]=1 from edge 12, AnyEvent=1 from edge 12.
- Ch1 Mode=11, In[1] toggled every cycle for 4 cycles → 4 consecutive Pulse[1] cycles. Ch2 Mode=10 with the same stimulus → pulses only on falls (2 pulses).
- Sticky[3] set, Clr[3]=1 held in the same cycle as a new ev[3] → Sticky[3] stays 1. Clr[3] alone next cycle → Sticky[3]=0, AnyEvent=0 one edge later.
- EDGE_COUNT_EN, CNT_W=4: 20 rising edges on ch4 → Count[4]=15 (saturated). Clr with a simultaneous edge → Count[4]=1.
- Reset_n=0 asserted while Pulse[5]=1 and Count[5]=7 → all outputs 0 at that edge, and pulses stay suppressed for SYNC_STAGES+1 cycles after release.
